// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with start-glitch rejection, optional parity, stop check.
// Build option UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote around the decision edge.
module uart_rx_frame #(
  parameter int unsigned Data_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [5:0]         PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [Data_WD-1:0] P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  localparam logic [3:0] LastBit = 4'(Data_WD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [5:0]         prescale_q, prescale_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic [5:0]         edge_cnt_q, edge_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [Data_WD-1:0] sh_q, sh_d;
  logic               par_bad_q, par_bad_d;
  logic [Data_WD-1:0] p_data_q, p_data_d;
  logic               valid_q, valid_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;

  logic [5:0] half;
  logic       dec_edge;
  logic       wrap;
  logic       bit_val;
  logic       counting;

  assign half     = {1'b0, prescale_q[5:1]};
  assign dec_edge = (edge_cnt_q == half + 6'd1);
  // The cap at 31 keeps every state moving even when the latched ratio is out of range.
  assign wrap     = (edge_cnt_q == prescale_q - 6'd1) || (edge_cnt_q == 6'd31);
  assign counting = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);

`ifdef UART_RX_MAJORITY_EN
  logic vote0_q, vote0_d;
  logic vote1_q, vote1_d;

  always_comb begin
    vote0_d = vote0_q;
    vote1_d = vote1_q;
    if (edge_cnt_q == half - 6'd1) vote0_d = rx_s_q;
    if (edge_cnt_q == half)        vote1_d = rx_s_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      vote0_q <= vote0_d;
      vote1_q <= vote1_d;
    end
  end

  assign bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    par_bad_d  = par_bad_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    if (counting) edge_cnt_d = wrap ? 6'd0 : edge_cnt_q + 6'd1;

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = 6'd0;
        if (!rx_s_q) begin
          state_d    = StStart;
          edge_cnt_d = 6'd1;
          bit_cnt_d  = 4'd0;
          par_bad_d  = 1'b0;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      StStart: begin
        if (dec_edge && bit_val) begin
          state_d    = StIdle;
          edge_cnt_d = 6'd0;
        end else if (wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        // LSB arrives first, so shifting in at the top leaves it at bit 0 after Data_WD bits.
        if (dec_edge) sh_d = {bit_val, sh_q[Data_WD-1:1]};
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = 4'd0;
            state_d   = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (dec_edge) par_bad_d = ((^sh_q) ^ par_typ_q) != bit_val;
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (dec_edge) begin
          edge_cnt_d = 6'd0;
          par_err_d  = par_bad_q;
          if (bit_val) begin
            state_d = StIdle;
            if (!par_bad_q) begin
              p_data_d = sh_q;
              valid_d  = 1'b1;
            end
          end else begin
            stp_err_d = 1'b1;
            state_d   = StBrkWait;
          end
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      StBrkWait: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      prescale_q <= 6'd0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= 4'd0;
      sh_q       <= '0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      rx_meta_q  <= RX_IN;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      par_bad_q  <= par_bad_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized bench for uart_rx_frame: frames are scored against a pulse/timing reference model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int unsigned W = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int GlitchSpan = 2;
`else
  localparam int GlitchSpan = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [5:0]   prescale = 6'd8;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic [W-1:0] p_data;
  logic         data_valid, par_err, stp_err;

  uart_rx_frame #(.Data_WD(W)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]   kind;  // 0 valid, 1 parity error, 2 stop error
    logic [31:0]  cyc;
    logic [W-1:0] data;
  } ev_t;

  ev_t          obs_q[$];
  ev_t          exp_q[$];
  logic [W-1:0] p_exp = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic ev_t mk_ev(input logic [1:0] kind, input int c, input logic [W-1:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (data_valid) obs_q.push_back(mk_ev(2'd0, cyc, p_data));
    if (par_err)    obs_q.push_back(mk_ev(2'd1, cyc, '0));
    if (stp_err)    obs_q.push_back(mk_ev(2'd2, cyc, '0));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic compare_logs(input string tag);
    int n;
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      check_eq({tag, "_cyc"},  obs_q[i].cyc, exp_q[i].cyc);
      check_eq({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    check_eq({tag, "_p_data"}, 32'(p_data), 32'(p_exp));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Drives one frame and records what the receiver must report for it.
  // glitch: slot within each data bit to invert for one cycle (-1 = none).
  task automatic send_frame(input logic [W-1:0] data, input logic [5:0] p, input logic pe,
                            input logic pt, input logic pbit, input logic stopb,
                            input int glitch, input logic toggle);
    int         k, nbits, s, t_dec, ones;
    logic       perr;
    logic [W+2:0] bits;
    prescale = p;
    par_en   = pe;
    par_typ  = pt;
    nbits    = pe ? W + 3 : W + 2;
    bits     = '0;
    for (int i = 0; i < W; i++) bits[i+1] = data[i];
    if (pe) begin
      bits[W+1] = pbit;
      bits[W+2] = stopb;
    end else begin
      bits[W+1] = stopb;
    end
    k = cyc;
    s = nbits - 1;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < int'(p); j++) begin
        rx = bits[b];
        if (b >= 1 && b <= W && j == glitch) rx = ~bits[b];
        if (toggle && b == 3 && j == 0) begin
          par_typ  = ~par_typ;
          par_en   = ~par_en;
          prescale = (p == 6'd8) ? 6'd32 : 6'd8;
        end
        tick(1);
      end
    end
    ones  = $countones(data);
    perr  = pe && (((ones + int'(pbit) + int'(pt)) % 2) == 1);
    // stop-bit leading edge + 2 sync + decision offset + output register
    t_dec = k + s * int'(p) + 2 + int'(p) / 2 + 1 + 1;
    if (stopb && !perr) begin
      exp_q.push_back(mk_ev(2'd0, t_dec, data));
      p_exp = data;
    end
    if (perr)   exp_q.push_back(mk_ev(2'd1, t_dec, '0));
    if (!stopb) exp_q.push_back(mk_ev(2'd2, t_dec, '0));
  endtask

  logic [5:0] p_tab [3];

  initial begin
    logic [W-1:0] d;
    logic [5:0]   p;
    logic         pe, pt, pb, sb, tg;
    int           g;
    p_tab[0] = 6'd8;
    p_tab[1] = 6'd16;
    p_tab[2] = 6'd32;

    tick(3);
    check_eq("rst_p_data", 32'(p_data), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_par_err", 32'(par_err), 32'h0);
    check_eq("rst_stp_err", 32'(stp_err), 32'h0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t1");

    send_frame(8'hA5, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t2_good");
    send_frame(8'hA5, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t2_par");

    send_frame(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t3_good");
    send_frame(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    idle(6);
    compare_logs("t3_toggle");

    send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    rx = 1'b0;
    tick(5 * 16);
    idle(20);
    compare_logs("t4_break");
    send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t4_recover");

    prescale = 6'd16;
    rx = 1'b0;
    tick(3);
    idle(40);
    compare_logs("t5_glitch");
    send_frame(8'h12, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h34, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("t5_b2b");

    // Reset in the middle of data bit 4
    d = 8'hF0;
    prescale = 6'd16;
    par_en = 1'b0;
    rx = 1'b0;
    tick(16);
    for (int b = 0; b < 5; b++) begin
      rx = d[b];
      tick((b == 4) ? 5 : 16);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    p_exp = '0;
    tick(3);
    check_eq("t6_rst_p_data", 32'(p_data), 32'h0);
    check_eq("t6_rst_valid", 32'(data_valid), 32'h0);
    rst_n = 1'b1;
    idle(60);
    compare_logs("t6_abort");

    send_frame(8'hC3, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    idle(6);
    compare_logs("t6_glitch_mid");
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hC3, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    idle(6);
    compare_logs("t6_glitch_dec");
`endif

    // Out-of-range ratio: result is don't-care, but the receiver must come back.
    prescale = 6'd0;
    rx = 1'b0;
    tick(40);
    idle(600);
    obs_q.delete();
    send_frame(8'h6B, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(6);
    compare_logs("illegal_recover");

    for (int n = 0; n < 40; n++) begin
      d  = W'($urandom);
      p  = p_tab[$urandom_range(0, 2)];
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      tg = 1'($urandom);
      g  = ($urandom_range(0, 1) != 0) ?
           (int'(p) / 2 - 1 + int'($urandom_range(0, GlitchSpan))) : -1;
      send_frame(d, p, pe, pt, pb, sb, g, tg);
      if (!sb) begin
        rx = 1'b0;
        tick(int'($urandom_range(0, 3 * int'(p))));
        idle(2 + int'($urandom_range(0, int'(p))));
      end else begin
        idle(int'($urandom_range(0, int'(p))));
      end
      if (n % 8 == 7) begin
        idle(8);
        compare_logs("rand");
      end
    end
    idle(8);
    compare_logs("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
